block_b_apb_regs: RTL and testbench
===================================

Name: block_b_apb_regs

Overview:
- APB3 completer (slave) register block for blockB, sitting behind the system APB decoder on the apbReg interface (apb_if, dst side, 32-bit address/data).
- Provides an ID register, control and scratch registers, a write-event counter and a 16-word RAM-style register array.
- The upstream decoder asserts psel only for blockB's window, so the block decodes local offset paddr[11:0] only.

Parameters:
- ADDR_W, 32, APB address width (apbAddrSt).
- DATA_W, 32, APB data width (apbDataSt).
- MEM_DEPTH, 16, number of 32-bit words in the register array.
- ID_VALUE, 32'h000B_0001, constant returned by the ID register.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- apbReg_paddr  input  ADDR_W  transfer address; only bits [11:0] decoded.
- apbReg_psel  input  1  completer select.
- apbReg_penable  input  1  access phase indicator.
- apbReg_pwrite  input  1  1=write, 0=read.
- apbReg_pwdata  input  DATA_W  write data.
- apbReg_pready  output  1  transfer complete.
- apbReg_prdata  output  DATA_W  read data.
- apbReg_pslverr  output  1  transfer error.

Behaviour:
- Register map (offset = paddr[11:0]):
  - 0x000 ID: RO, ID_VALUE.
  - 0x004 CTRL: RW, reset 0.
  - 0x008 SCRATCH: RW, reset 0.
  - 0x00C WRCNT: RO, count of successful writes; 32-bit, wraps 0xFFFF_FFFF->0; reset 0.
  - 0x100..0x13C MEM[0..15]: RW, index = paddr[5:2], reset 0.
- Setup phase (psel=1, penable=0): on that clk edge, register decode result, read data and error flag.
- Access phase (psel=1, penable=1):
  - pready=1 combinationally; zero wait states, so every transfer completes in exactly 2 cycles.
  - prdata/pslverr come from the values registered at setup.
- pready=0 whenever not in the access phase.
- Errors (pslverr=1 in the access phase):
  - Unaligned (paddr[1:0]!=0).
  - Unmapped offset.
  - Write to ID or WRCNT.
  - On error: prdata=0, no state changes, WRCNT does not increment.
- Writes:
  - Commit on the access-phase edge (psel & penable & pwrite & no error); full 32-bit write, no byte strobes.
  - WRCNT increments by 1 on that same edge.
  - A write to WRCNT itself is an error and does not increment.
- Reads: no side effects. prdata=0 on write transfers and outside the access phase.
- Back-to-back transfers (new setup the cycle after access) are fully supported; a read of a register written in the immediately preceding transfer returns the new value.
- psel dropping mid-transfer (setup not followed by access) is silently discarded: no write, no counter change.
- Reset (rst=1 at a clk edge):
  - pready=0, prdata=0, pslverr=0.
  - CTRL, SCRATCH, WRCNT, all MEM words = 0.
  - Any in-flight transfer is aborted with no write.
- Reset dominates a simultaneous write.

Test Plan:
- After reset, read 0x000/0x004/0x00C -> prdata 0x000B0001/0x0/0x0, pslverr=0, pready high in 2nd cycle of each transfer.
- Write 0xDEADBEEF to 0x008, read back -> 0xDEADBEEF; WRCNT read -> 1.
- Write MEM[0]=0x11, MEM[15]=0xFF at 0x100/0x13C; read both -> 0x11/0xFF; read 0x140 -> pslverr=1, prdata=0.
- Write 0x1234 to 0x000, write to 0x006 (unaligned) -> pslverr=1 both; ID unchanged, WRCNT unchanged.
- Assert rst between setup and access of a write to CTRL=0x5 -> CTRL reads 0, WRCNT 0, outputs 0 during reset.
- Back-to-back write CTRL=0xA then read CTRL with no idle cycle -> 0xA; 3 writes then WRCNT -> 3.

Source files
------------

// File: rtl/block_b_apb_regs.sv
// blockB APB3 completer: ID, CTRL, SCRATCH, write counter and a small word array.
// Zero-wait-state; decode, read data and error are captured on the setup edge.
module block_b_apb_regs #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'h000B_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] apbReg_paddr,
  input  logic              apbReg_psel,
  input  logic              apbReg_penable,
  input  logic              apbReg_pwrite,
  input  logic [DATA_W-1:0] apbReg_pwdata,
  output logic              apbReg_pready,
  output logic [DATA_W-1:0] apbReg_prdata,
  output logic              apbReg_pslverr
);

  localparam int unsigned OFF_W    = 12;
  localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [OFF_W-1:0] OFF_ID      = 12'h000;
  localparam logic [OFF_W-1:0] OFF_CTRL    = 12'h004;
  localparam logic [OFF_W-1:0] OFF_SCRATCH = 12'h008;
  localparam logic [OFF_W-1:0] OFF_WRCNT   = 12'h00C;
  localparam logic [OFF_W-1:0] MEM_BASE    = 12'h100;
  localparam logic [OFF_W-1:0] MEM_END     = OFF_W'(32'h100 + MEM_DEPTH * 4);

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_ID,
    TGT_CTRL,
    TGT_SCRATCH,
    TGT_WRCNT,
    TGT_MEM
  } tgt_e;

  logic [DATA_W-1:0] ctrl_q;
  logic [DATA_W-1:0] scratch_q;
  logic [DATA_W-1:0] wrcnt_q;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic              setup_q;
  logic              wr_q;
  logic              err_q;
  tgt_e              tgt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] rdata_q;

  logic [OFF_W-1:0]  off_c;
  tgt_e              tgt_c;
  logic [IDX_W-1:0]  idx_c;
  logic              err_c;
  logic [DATA_W-1:0] rd_c;
  logic              setup_c;
  logic              access_c;
  logic              commit_c;
  logic              unused_paddr_hi;

  assign off_c           = apbReg_paddr[OFF_W-1:0];
  assign unused_paddr_hi = &{1'b0, apbReg_paddr[ADDR_W-1:OFF_W]};
  assign setup_c         = apbReg_psel & ~apbReg_penable;
  assign access_c        = apbReg_psel & apbReg_penable & ~rst;
  assign commit_c        = access_c & setup_q & wr_q & ~err_q;

  // Local offset decode, error classification and read mux for the setup phase.
  always_comb begin
    tgt_c = TGT_NONE;
    idx_c = '0;
    err_c = 1'b0;
    rd_c  = '0;
    if (off_c[1:0] != 2'b00) begin
      err_c = 1'b1;
    end else if (off_c == OFF_ID) begin
      tgt_c = TGT_ID;
      rd_c  = ID_VALUE;
    end else if (off_c == OFF_CTRL) begin
      tgt_c = TGT_CTRL;
      rd_c  = ctrl_q;
    end else if (off_c == OFF_SCRATCH) begin
      tgt_c = TGT_SCRATCH;
      rd_c  = scratch_q;
    end else if (off_c == OFF_WRCNT) begin
      tgt_c = TGT_WRCNT;
      rd_c  = wrcnt_q;
    end else if (off_c >= MEM_BASE && off_c < MEM_END) begin
      tgt_c = TGT_MEM;
      idx_c = IDX_W'((off_c - MEM_BASE) >> 2);
      rd_c  = mem_q[idx_c];
    end else begin
      err_c = 1'b1;
    end
    if (apbReg_pwrite && (tgt_c == TGT_ID || tgt_c == TGT_WRCNT)) begin
      err_c = 1'b1;
    end
    if (apbReg_pwrite || err_c) begin
      rd_c = '0;
    end
  end

  // Setup-edge capture and access-edge write commit; reset wins over any commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      setup_q   <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      tgt_q     <= TGT_NONE;
      idx_q     <= '0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      scratch_q <= '0;
      wrcnt_q   <= '0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      setup_q <= setup_c;
      if (setup_c) begin
        wr_q    <= apbReg_pwrite;
        err_q   <= err_c;
        tgt_q   <= tgt_c;
        idx_q   <= idx_c;
        rdata_q <= rd_c;
      end else begin
        wr_q    <= 1'b0;
        err_q   <= 1'b0;
        tgt_q   <= TGT_NONE;
        rdata_q <= '0;
      end
      if (commit_c) begin
        case (tgt_q)
          TGT_CTRL:    ctrl_q        <= apbReg_pwdata;
          TGT_SCRATCH: scratch_q     <= apbReg_pwdata;
          TGT_MEM:     mem_q[idx_q]  <= apbReg_pwdata;
          default:     ;
        endcase
        wrcnt_q <= wrcnt_q + DATA_W'(1);
      end
    end
  end

  assign apbReg_pready  = access_c;
  assign apbReg_prdata  = access_c ? rdata_q : '0;
  assign apbReg_pslverr = access_c & err_q;

endmodule

// File: tb/tb_block_b_apb_regs.sv
// Self-checking bench for block_b_apb_regs: directed register-map cases plus
// randomized transfers against a register-map model.
module tb_block_b_apb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  // Register-map model
  logic [31:0] m_ctrl, m_scratch, m_wrcnt;
  logic [31:0] m_mem [16];
  localparam logic [31:0] ID = 32'h000B_0001;

  block_b_apb_regs dut (
    .clk            (clk),
    .rst            (rst),
    .apbReg_paddr   (paddr),
    .apbReg_psel    (psel),
    .apbReg_penable (penable),
    .apbReg_pwrite  (pwrite),
    .apbReg_pwdata  (pwdata),
    .apbReg_pready  (pready),
    .apbReg_prdata  (prdata),
    .apbReg_pslverr (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ctrl = 0; m_scratch = 0; m_wrcnt = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
  endfunction

  // Applies one completed transfer to the model and returns expected prdata/pslverr.
  function automatic void model_xfer(input logic [31:0] addr, input bit wr,
                                     input logic [31:0] wd,
                                     output logic [31:0] rd, output bit err);
    int off;
    off = int'(addr[11:0]);
    err = 1'b0;
    rd  = 32'h0;
    if (off % 4 != 0) err = 1'b1;
    else if (off == 0)  begin if (wr) err = 1'b1; else rd = ID; end
    else if (off == 4)  begin if (wr) m_ctrl = wd; else rd = m_ctrl; end
    else if (off == 8)  begin if (wr) m_scratch = wd; else rd = m_scratch; end
    else if (off == 12) begin if (wr) err = 1'b1; else rd = m_wrcnt; end
    else if (off >= 256 && off < 256 + 64) begin
      if (wr) m_mem[(off - 256) / 4] = wd; else rd = m_mem[(off - 256) / 4];
    end
    else err = 1'b1;
    if (wr && !err) m_wrcnt = m_wrcnt + 1;
    if (wr || err) rd = 32'h0;
  endfunction

  // Full two-cycle transfer; call #1 after a rising edge, returns #1 after the access edge.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                      output logic [31:0] rd_obs, output bit err_obs);
    logic [31:0] e_rd;
    bit          e_err;
    model_xfer(addr, wr, wd, e_rd, e_err);
    paddr = addr; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    chk("pready_setup", 32'(pready), 32'h0);
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rd_obs  = prdata;
    err_obs = pslverr;
    chk("pready_access", 32'(pready), 32'h1);
    chk($sformatf("prdata@%03h", addr[11:0]), prdata, e_rd);
    chk($sformatf("pslverr@%03h", addr[11:0]), 32'(pslverr), 32'(e_err));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("pready_idle", 32'(pready), 32'h0);
      chk("prdata_idle", prdata, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;
  bit          er;
  logic [31:0] r32;
  logic [31:0] addr;
  int          k;

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 0; pwdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", 32'(pready), 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Reset values
    xfer(32'h000, 0, 0, rd, er); chk("id_val", rd, 32'h000B_0001);
    xfer(32'h004, 0, 0, rd, er); chk("ctrl_rst", rd, 32'h0);
    xfer(32'h00C, 0, 0, rd, er); chk("wrcnt_rst", rd, 32'h0);
    idle(1);

    // Scratch write/readback and counter
    xfer(32'h008, 1, 32'hDEAD_BEEF, rd, er);
    xfer(32'h008, 0, 0, rd, er); chk("scratch_rb", rd, 32'hDEAD_BEEF);
    xfer(32'h00C, 0, 0, rd, er); chk("wrcnt_1", rd, 32'h1);

    // Array end points and one past the end
    xfer(32'h100, 1, 32'h11, rd, er);
    xfer(32'h13C, 1, 32'hFF, rd, er);
    xfer(32'h100, 0, 0, rd, er); chk("mem0", rd, 32'h11);
    xfer(32'h13C, 0, 0, rd, er); chk("mem15", rd, 32'hFF);
    xfer(32'h140, 0, 0, rd, er); chk("oob_err", 32'(er), 32'h1);

    // Write to ID and unaligned write are errors without side effects
    xfer(32'h000, 1, 32'h1234, rd, er); chk("id_wr_err", 32'(er), 32'h1);
    xfer(32'h006, 1, 32'h55, rd, er);   chk("unal_err", 32'(er), 32'h1);
    xfer(32'h00C, 1, 32'h77, rd, er);   chk("wrcnt_wr_err", 32'(er), 32'h1);
    xfer(32'h000, 0, 0, rd, er); chk("id_kept", rd, 32'h000B_0001);
    xfer(32'h00C, 0, 0, rd, er); chk("wrcnt_kept", rd, 32'h3);
    idle(2);

    // Reset between setup and access of a CTRL write
    paddr = 32'h004; pwrite = 1'b1; pwdata = 32'h5; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pready", 32'(pready), 32'h0);
    chk("rst_mid_prdata", prdata, 32'h0);
    chk("rst_mid_pslverr", 32'(pslverr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    model_reset();
    idle(1);
    xfer(32'h004, 0, 0, rd, er); chk("ctrl_after_rst", rd, 32'h0);
    xfer(32'h00C, 0, 0, rd, er); chk("wrcnt_after_rst", rd, 32'h0);
    xfer(32'h13C, 0, 0, rd, er); chk("mem15_after_rst", rd, 32'h0);

    // Back-to-back write then read, then counter after three writes
    xfer(32'h004, 1, 32'hA, rd, er);
    xfer(32'h004, 0, 0, rd, er); chk("b2b_ctrl", rd, 32'hA);
    xfer(32'h008, 1, 32'h1, rd, er);
    xfer(32'h120, 1, 32'h2, rd, er);
    xfer(32'h00C, 0, 0, rd, er); chk("wrcnt_3", rd, 32'h3);

    // Aborted setup (psel drops): no write, no count
    paddr = 32'h004; pwrite = 1'b1; pwdata = 32'hBAD; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    psel = 1'b0;
    idle(1);
    xfer(32'h004, 0, 0, rd, er); chk("abort_ctrl", rd, 32'hA);
    xfer(32'h00C, 0, 0, rd, er); chk("abort_wrcnt", rd, 32'h3);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 11);
      r32 = $urandom();
      case (k)
        0, 1, 2, 3: addr = 32'(k * 4);
        4, 5, 6, 7: addr = 32'h100 + 32'($urandom_range(0, 15) * 4);
        8:          addr = 32'h100 + 32'($urandom_range(0, 63));
        9:          addr = 32'($urandom_range(0, 4095));
        10:         addr = 32'h140 + 32'($urandom_range(0, 3) * 4);
        default:    addr = 32'h010;
      endcase
      addr[31:12] = r32[31:12];
      if ($urandom_range(0, 15) == 0) begin
        paddr = addr; pwrite = 1'b1; pwdata = $urandom(); psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        psel = 1'b0;
      end else begin
        xfer(addr, 1'($urandom_range(0, 1)), $urandom(), rd, er);
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // Final sweep of all readable state
    xfer(32'h004, 0, 0, rd, er);
    xfer(32'h008, 0, 0, rd, er);
    xfer(32'h00C, 0, 0, rd, er);
    for (int i = 0; i < 16; i++) xfer(32'h100 + 32'(i * 4), 0, 0, rd, er);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
